// File: rtl/dbus_uncached_router_if.sv
// Bus bundle around dbus_uncached_router.
// Groups the four handshakes the router touches:
//   t_*    : translated CPU request plus its d_uncached flag (into the router)
//   dresp_*: merged response back to the CPU
//   dc_*   : request to the DCache and its response
//   uc_*   : single-beat CBus request for uncached accesses and its response
// Modports:
//   slave  : the router's view
//   master : the surrounding environment's view (CPU/DCache/CBus side)
interface dbus_uncached_router_if;
  // translated CPU request
  logic        t_valid;
  logic [31:0] t_addr;
  logic [2:0]  t_size;
  logic [3:0]  t_strobe;
  logic [31:0] t_data;
  logic        d_uncached;
  // response to CPU
  logic        dresp_addr_ok;
  logic        dresp_data_ok;
  logic [31:0] dresp_data;
  // DCache request / response
  logic        dc_valid;
  logic [31:0] dc_addr;
  logic [2:0]  dc_size;
  logic [3:0]  dc_strobe;
  logic [31:0] dc_data;
  logic        dc_addr_ok;
  logic        dc_data_ok;
  logic [31:0] dc_rdata;
  // uncached CBus request / response
  logic        uc_valid;
  logic        uc_is_write;
  logic [2:0]  uc_size;
  logic [31:0] uc_addr;
  logic [3:0]  uc_strobe;
  logic [31:0] uc_data;
  logic [3:0]  uc_len;
  logic [1:0]  uc_burst;
  logic        uc_ready;
  logic        uc_last;
  logic [31:0] uc_rdata;

  modport slave (
    input  t_valid, t_addr, t_size, t_strobe, t_data, d_uncached,
    output dresp_addr_ok, dresp_data_ok, dresp_data,
    output dc_valid, dc_addr, dc_size, dc_strobe, dc_data,
    input  dc_addr_ok, dc_data_ok, dc_rdata,
    output uc_valid, uc_is_write, uc_size, uc_addr, uc_strobe, uc_data, uc_len, uc_burst,
    input  uc_ready, uc_last, uc_rdata
  );

  modport master (
    output t_valid, t_addr, t_size, t_strobe, t_data, d_uncached,
    input  dresp_addr_ok, dresp_data_ok, dresp_data,
    input  dc_valid, dc_addr, dc_size, dc_strobe, dc_data,
    output dc_addr_ok, dc_data_ok, dc_rdata,
    input  uc_valid, uc_is_write, uc_size, uc_addr, uc_strobe, uc_data, uc_len, uc_burst,
    output uc_ready, uc_last, uc_rdata
  );
endinterface

// File: rtl/dbus_uncached_router.sv
// dbus_uncached_router
// Routes translated data requests either to the DCache (cacheable) or to a
// single-beat CBus transaction (uncached), and merges both response streams
// into one CPU response in program order.
// Ports:
//   clk    : system clock
//   resetn : asynchronous active-low reset; every output is 0 while low
//   bus    : dbus_uncached_router_if.slave (CPU request/response, DCache, CBus)
// Parameters:
//   MAX_PENDING : cached requests accepted by the DCache but not yet data_ok
module dbus_uncached_router #(
  parameter int MAX_PENDING = 4
) (
  input logic                   clk,
  input logic                   resetn,
  dbus_uncached_router_if.slave bus
);

  localparam int              CNT_W           = $clog2(MAX_PENDING + 1);
  localparam logic [CNT_W-1:0] MAX_CNT        = CNT_W'(MAX_PENDING);
  localparam logic [3:0]      MLEN1           = 4'b0000;
  localparam logic [1:0]      AXI_BURST_FIXED = 2'b00;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    UC_BUS  = 2'd1,
    UC_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_pend_cnt;
  logic [31:0]      r_buf_addr;
  logic [2:0]       r_buf_size;
  logic [3:0]       r_buf_strobe;
  logic [31:0]      r_buf_data;
  logic [31:0]      r_uc_rdata;

  logic w_idle;
  logic w_dc_valid;
  logic w_cached_accept;
  logic w_uc_accept;
  logic w_dec;

  assign w_idle          = (r_state == IDLE);
  // Cached requests flow only in IDLE and only while the outstanding window has room.
  assign w_dc_valid      = w_idle & bus.t_valid & ~bus.d_uncached & (r_pend_cnt < MAX_CNT);
  assign w_cached_accept = w_dc_valid & bus.dc_addr_ok;
  // An uncached access may start only once every cached response has returned,
  // which keeps responses in program order without a reorder buffer.
  assign w_uc_accept     = w_idle & bus.t_valid & bus.d_uncached & (r_pend_cnt == '0);
  assign w_dec           = bus.dc_data_ok;

  // Outputs are forced low while resetn is asserted, including the
  // combinational pass-through paths.
  always_comb begin
    bus.dresp_addr_ok = 1'b0;
    bus.dresp_data_ok = 1'b0;
    bus.dresp_data    = '0;
    bus.dc_valid      = 1'b0;
    bus.dc_addr       = '0;
    bus.dc_size       = '0;
    bus.dc_strobe     = '0;
    bus.dc_data       = '0;
    bus.uc_valid      = 1'b0;
    bus.uc_is_write   = 1'b0;
    bus.uc_size       = '0;
    bus.uc_addr       = '0;
    bus.uc_strobe     = '0;
    bus.uc_data       = '0;
    bus.uc_len        = '0;
    bus.uc_burst      = '0;
    if (resetn) begin
      bus.dc_valid      = w_dc_valid;
      bus.dc_addr       = bus.t_addr;
      bus.dc_size       = bus.t_size;
      bus.dc_strobe     = bus.t_strobe;
      bus.dc_data       = bus.t_data;
      bus.dresp_addr_ok = w_cached_accept | w_uc_accept;
      if (r_state == UC_DONE) begin
        bus.dresp_data_ok = 1'b1;
        bus.dresp_data    = r_uc_rdata;
      end else begin
        bus.dresp_data_ok = bus.dc_data_ok;
        bus.dresp_data    = bus.dc_rdata;
      end
      // CBus request is driven purely from registers, so it is stable for the
      // whole access regardless of what the CPU does meanwhile.
      bus.uc_valid    = (r_state == UC_BUS);
      bus.uc_is_write = |r_buf_strobe;
      bus.uc_size     = r_buf_size;
      bus.uc_addr     = r_buf_addr;
      bus.uc_strobe   = r_buf_strobe;
      bus.uc_data     = r_buf_data;
      bus.uc_len      = MLEN1;
      bus.uc_burst    = AXI_BURST_FIXED;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_pend_cnt   <= '0;
      r_buf_addr   <= '0;
      r_buf_size   <= '0;
      r_buf_strobe <= '0;
      r_buf_data   <= '0;
      r_uc_rdata   <= '0;
    end else begin
      // A simultaneous accept and data_ok leaves the count unchanged.
      case ({w_cached_accept, w_dec})
        2'b10:   r_pend_cnt <= r_pend_cnt + CNT_W'(1);
        2'b01:   r_pend_cnt <= r_pend_cnt - CNT_W'(1);
        default: r_pend_cnt <= r_pend_cnt;
      endcase

      case (r_state)
        IDLE: begin
          if (w_uc_accept) begin
            r_buf_addr   <= bus.t_addr;
            r_buf_size   <= bus.t_size;
            r_buf_strobe <= bus.t_strobe;
            r_buf_data   <= bus.t_data;
            r_state      <= UC_BUS;
          end
        end
        UC_BUS: begin
          if (bus.uc_ready & bus.uc_last) begin
            r_uc_rdata <= bus.uc_rdata;
            r_state    <= UC_DONE;
          end
        end
        UC_DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  a_no_underflow: assert property (@(posedge clk) disable iff (!resetn)
    !(bus.dc_data_ok && (r_pend_cnt == '0)));
  a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
    r_pend_cnt <= MAX_CNT);

endmodule
